// File: rtl/nco_sched_pkg.sv
// Shared types and defaults for the NCO tick scheduler.
package nco_sched_pkg;

    localparam int unsigned DEF_CH    = 4;
    localparam int unsigned DEF_DIV_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } sched_state_e;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
    import nco_sched_pkg::*;
#(
    parameter  int unsigned CH   = DEF_CH,
    localparam int unsigned CH_W = ch_w(CH)
) (
    input  logic [CH-1:0]   req,
    input  logic [CH_W-1:0] ptr,
    output logic            gnt_valid_c,
    output logic [CH_W-1:0] gnt_idx_c
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        idx         = 0;
        for (int k = int'(CH) - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= int'(CH)) begin
                idx = idx - int'(CH);
            end
            if (req[CH_W'(idx)]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/nco_tick_sched.sv
// Multi-channel rate scheduler producing round-robin step strobes for a shared NCO.
module nco_tick_sched
    import nco_sched_pkg::*;
#(
    parameter  int unsigned CH    = DEF_CH,
    parameter  int unsigned DIV_W = DEF_DIV_W,
    localparam int unsigned CH_W  = ch_w(CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             next,
    output logic [CH_W-1:0]  next_ch,
    output logic [CH-1:0]    overrun
);

    sched_state_e     state_q, state_d;
    logic             ready_d;
    logic             accept;

    logic [DIV_W-1:0] div_q [CH];
    logic [DIV_W-1:0] cnt_q [CH];
    logic [CH-1:0]    en_q;
    logic [CH-1:0]    pend_q;
    logic [CH-1:0]    ovr_q;
    logic [CH_W-1:0]  rr_q;

    logic [CH-1:0]    wr_hit;
    logic [CH-1:0]    due;
    logic [CH-1:0]    gnt_oh;
    logic             gnt_valid;
    logic [CH_W-1:0]  gnt_idx;

    assign accept  = cfg_valid & cfg_ready;
    assign overrun = ovr_q;

    // Config handshake state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cfg_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_ready <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    rr_arbiter #(.CH(CH)) u_arb (
        .req         (pend_q),
        .ptr         (rr_q),
        .gnt_valid_c (gnt_valid),
        .gnt_idx_c   (gnt_idx)
    );

    // Out-of-range cfg_ch matches no channel, so the write completes with no effect.
    always_comb begin
        wr_hit = '0;
        due    = '0;
        gnt_oh = '0;
        for (int i = 0; i < int'(CH); i++) begin
            wr_hit[i] = accept && (cfg_ch == CH_W'(i));
            due[i]    = !wr_hit[i] && en_q[i] && (cnt_q[i] == '0);
            gnt_oh[i] = gnt_valid && (gnt_idx == CH_W'(i));
        end
    end

    // Per-channel counters, pending and overrun flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CH); i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            en_q   <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                if (wr_hit[i]) begin
                    div_q[i]  <= cfg_div;
                    en_q[i]   <= cfg_en;
                    cnt_q[i]  <= cfg_div;
                    pend_q[i] <= 1'b0;
                    ovr_q[i]  <= 1'b0;
                end else begin
                    if (en_q[i]) begin
                        cnt_q[i] <= (cnt_q[i] == '0) ? div_q[i] : cnt_q[i] - DIV_W'(1);
                    end
                    // A due channel stays pending even if granted this edge.
                    if (due[i]) begin
                        pend_q[i] <= 1'b1;
                        if (pend_q[i] && !gnt_oh[i]) begin
                            ovr_q[i] <= 1'b1;
                        end
                    end else if (gnt_oh[i]) begin
                        pend_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Strobe output and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next    <= 1'b0;
            next_ch <= '0;
            rr_q    <= '0;
        end else begin
            next <= gnt_valid;
            if (gnt_valid) begin
                next_ch <= gnt_idx;
                rr_q    <= (gnt_idx == CH_W'(CH - 1)) ? '0 : gnt_idx + CH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nco_tick_sched.sv
// Bench for nco_tick_sched: cycle model feeding a scoreboard plus directed scenarios.
module tb_nco_tick_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic        next;
    logic [1:0]  next_ch;
    logic [3:0]  overrun;

    logic        u3_ready;
    logic        u3_next;
    logic [1:0]  u3_nch;
    logic [2:0]  u3_ovr;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nco_tick_sched #(.CH(4), .DIV_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .next      (next),
        .next_ch   (next_ch),
        .overrun   (overrun)
    );

    // Three-channel copy always addressed at index 3, which does not exist.
    nco_tick_sched #(.CH(3), .DIV_W(16)) u3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (u3_ready),
        .cfg_ch    (2'd3),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .next      (u3_next),
        .next_ch   (u3_nch),
        .overrun   (u3_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic       ready;
        logic       nxt;
        logic [1:0] nch;
        logic [3:0] ovr;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] m_cnt [4];
    logic [15:0] m_div [4];
    logic [3:0]  m_en, m_pend, m_ovr;
    int          m_rr;
    logic        m_next;
    logic [1:0]  m_nch;
    logic        m_ready;

    // Reference model, evaluated on the same edges as the DUT.
    always @(posedge clk) begin : model
        logic       acc, gv, dueb, gi;
        int         g;
        logic [3:0] np, no;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = '0;
                m_div[i] = '0;
            end
            m_en = '0; m_pend = '0; m_ovr = '0;
            m_rr = 0; m_next = 1'b0; m_nch = '0; m_ready = 1'b0;
        end else begin
            acc = cfg_valid && m_ready;
            gv  = 1'b0;
            g   = 0;
            for (int k = 0; k < 4; k++) begin
                if (!gv && m_pend[(m_rr + k) % 4]) begin
                    gv = 1'b1;
                    g  = (m_rr + k) % 4;
                end
            end
            np = m_pend;
            no = m_ovr;
            for (int i = 0; i < 4; i++) begin
                gi = gv && (g == i);
                if (acc && (cfg_ch == i)) begin
                    m_div[i] = cfg_div;
                    m_en[i]  = cfg_en;
                    m_cnt[i] = cfg_div;
                    np[i]    = 1'b0;
                    no[i]    = 1'b0;
                end else begin
                    dueb = m_en[i] && (m_cnt[i] == 0);
                    if (m_en[i]) m_cnt[i] = dueb ? m_div[i] : m_cnt[i] - 16'd1;
                    if (dueb) begin
                        if (m_pend[i] && !gi) no[i] = 1'b1;
                        np[i] = 1'b1;
                    end else if (gi) begin
                        np[i] = 1'b0;
                    end
                end
            end
            m_pend = np;
            m_ovr  = no;
            m_next = gv;
            if (gv) begin
                m_nch = 2'(g);
                m_rr  = (g + 1) % 4;
            end
            m_ready = !acc;
        end
        exp_q.push_back({m_ready, m_next, m_nch, m_ovr});
    end

    // Scoreboard: compare each edge's expected outputs at the following negedge.
    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_ready", 32'(cfg_ready), 32'(e.ready));
            chk("sb_next", 32'(next), 32'(e.nxt));
            if (e.nxt) chk("sb_next_ch", 32'(next_ch), 32'(e.nch));
            chk("sb_overrun", 32'(overrun), 32'(e.ovr));
            chk("oor_ready", 32'(u3_ready), 32'(e.ready));
            chk("oor_next", 32'(u3_next), 32'd0);
            chk("oor_overrun", 32'(u3_ovr), 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] dv, input logic en,
                             output int acc_at);
        int guard = 0;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_en    = en;
        while (!cfg_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cfg_ready) chk("cfg_accept_timeout", 32'(cfg_ready), 32'd1);
        acc_at = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0, a1, a2, k, prev, bad, strobes, cnt0;
        rst_n     = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;

        repeat (5) begin
            @(negedge clk);
            chk("rst_ready", 32'(cfg_ready), 32'd0);
            chk("rst_next", 32'(next), 32'd0);
            chk("rst_overrun", 32'(overrun), 32'd0);
        end
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("release_ready", 32'(cfg_ready), 32'd1);

        // Single channel, div=3.
        cfg_write(2'd0, 16'd3, 1'b1, a0);
        k = 1;
        while (!next && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("first_latency", 32'(k), 32'd6);
        prev = k; bad = 0; strobes = 0;
        repeat (100) begin
            @(negedge clk);
            k++;
            if (next) begin
                if (k - prev != 4) bad++;
                if (next_ch != 2'd0) bad++;
                prev = k;
                strobes++;
            end
        end
        chk("single_period", 32'(bad), 32'd0);
        chk("single_strobes", 32'(strobes), 32'd25);
        chk("single_overrun", 32'(overrun), 32'd0);

        // Back-to-back writes with cfg_valid held high.
        cfg_write(2'd1, 16'd100, 1'b0, a1);
        cfg_write(2'd2, 16'd100, 1'b0, a2);
        chk("hs_gap", 32'(a2 - a1), 32'd2);

        // Contention: all channels due every cycle.
        do_reset(2);
        for (int i = 0; i < 4; i++) cfg_write(2'(i), 16'd0, 1'b1, a0);
        repeat (12) @(negedge clk);
        prev = int'(next_ch); bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (!next || int'(next_ch) != (prev + 1) % 4) bad++;
            prev = int'(next_ch);
        end
        chk("cont_sequence", 32'(bad), 32'd0);
        chk("cont_overrun", 32'(overrun), 32'hF);
        cfg_write(2'd2, 16'd0, 1'b1, a0);
        chk("ovr2_cleared", 32'(overrun[2]), 32'd0);
        repeat (6) @(negedge clk);
        chk("ovr2_reset", 32'(overrun[2]), 32'd1);

        // Fair share: two channels at half rate.
        do_reset(2);
        cfg_write(2'd0, 16'd1, 1'b1, a0);
        cfg_write(2'd1, 16'd1, 1'b1, a0);
        repeat (10) @(negedge clk);
        prev = int'(next_ch); bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (!next || int'(next_ch) == prev) bad++;
            prev = int'(next_ch);
        end
        chk("fair_alternate", 32'(bad), 32'd0);
        chk("fair_overrun", 32'(overrun), 32'd0);

        // Disable ch0 mid-run.
        cfg_write(2'd0, 16'd1, 1'b0, a0);
        cnt0 = 0;
        repeat (20) begin
            @(negedge clk);
            if (next && next_ch == 2'd0) cnt0++;
        end
        chk("disable_ch0", 32'(cnt0), 32'd0);

        // Reset while strobing.
        k = 0;
        while (!next && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("pre_reset_next", 32'(next), 32'd1);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_next", 32'(next), 32'd0);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_next", 32'(next), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/nco_tick_sched.md
# nco_tick_sched

Multi-channel rate scheduler that generates the `next` step strobe for a shared sawtooth NCO (`nco_saw`). Each of CH channels has a programmable period; due channels are granted one NCO step per cycle in round-robin order, and the granted channel index accompanies the strobe so downstream logic can steer per-channel phase state. Configuration arrives over a valid/ready write port from the control plane.

## Interface
- `CH`, 4: number of channels, 1..16.
- `DIV_W`, 16: period register width; channel period = `div`+1 cycles.
- `CH_W`, `$clog2(CH)` (min 1): channel index width.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config write accepted when both high at a rising edge.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_div`  in  DIV_W  period minus one.
- `cfg_en`  in  1  channel enable.
- `next`  out  1  one-cycle step strobe to NCO `next` input.
- `next_ch`  out  CH_W  channel owning current `next`; valid only when `next`=1.
- `overrun`  out  CH  sticky per-channel flag: channel came due while still pending.

## Operation
- Per channel registers: `div`, `en`, down-counter `cnt`, `pending`, `overrun`.
- FSM `IDLE`/`APPLY`. `IDLE`: `cfg_ready`=1. Accept -> `APPLY` (`cfg_ready`=0 for exactly one cycle) -> `IDLE`. Max write rate one per two cycles.
- On accept edge for channel c: `div`<=`cfg_div`, `en`<=`cfg_en`, `cnt`<=`cfg_div`, `pending`<=0, `overrun[c]`<=0. That channel does no counting and no due event that edge; if it was being granted that edge, the grant still issues.
- `cfg_ch` >= CH: handshake completes, no state changes.
- Counting, each edge, enabled, not being written: `cnt`==0 -> `cnt`<=`div`, channel due; else `cnt`<=`cnt`-1. Disabled channel: `cnt`, `pending` hold.
- Due: `pending`<=1. If `pending` already 1 and not granted this edge -> `overrun`<=1, pending stays 1 (depth one, no queue).
- Grant, each edge: if any `pending`, pick first pending at or after `rr_ptr` (wrapping); `next`<=1, `next_ch`<=g, `pending[g]`<=0 unless g due the same edge (stays 1, no overrun), `rr_ptr`<=(g+1) mod CH. Nothing pending -> `next`<=0, `next_ch`, `rr_ptr` hold.
- `div`=0: channel due every enabled cycle; with >1 such channels overrun is expected.

## Timing
- Reset (`rst_n`=0 at an edge): all registers 0; `next`=0, `next_ch`=0, `overrun`=0, `rr_ptr`=0, FSM `IDLE`; `cfg_ready`=0 while `rst_n`=0, 1 from first cycle after release. Reset mid-operation drops all pending grants, no strobe follows.
- Single enabled channel, write accepted at edge E0 with `div`=D: due at E0+D+1, `next` high in cycle after E0+D+2, then every D+1 cycles.
- Due -> `next` latency: exactly one edge when uncontended; otherwise bounded by CH-1 further cycles.
- `next`, `next_ch`, `overrun`, `cfg_ready` all registered (or FSM-decoded); no combinational path from `cfg_*` to outputs.

## Structure
- Package `nco_sched_pkg`: FSM state enum (`IDLE`, `APPLY`), default `CH`/`DIV_W` constants.
- Sub-module `rr_arbiter` (#CH): inputs request vector and pointer, outputs grant valid and index; purely combinational, reused by other shared-resource blocks.
- Top holds channel register arrays, FSM, `next`/`next_ch` output registers.

## Test plan
- Reset: hold `rst_n`=0 5 cycles with `cfg_valid`=1 -> `cfg_ready`=0, `next`=0, `overrun`=0; release -> `cfg_ready`=1 next cycle.
- Single channel: write ch0 `div`=3 `en`=1 at E0 -> `next` first high after E0+5, then every 4 cycles, `next_ch`=0, `overrun`=0 over 100 cycles.
- Handshake: `cfg_valid` held high with two queued writes -> `cfg_ready` pattern 1,0,1; second write accepted two cycles after first; out-of-range `cfg_ch` accepted, no effect.
- Contention: all 4 channels `div`=0 -> `next` every cycle, `next_ch` sequence 0,1,2,3,0,..., all `overrun` bits set; rewrite ch2 -> `overrun[2]` clears then sets again.
- Fair share: ch0 `div`=1, ch1 `div`=1 written back-to-back -> `next` every cycle alternating channels, no overrun.
- Disable/reset mid-run: write ch0 `en`=0 -> no further `next` for ch0 after pending drains (at most zero strobes since write clears pending); assert `rst_n`=0 while strobing -> `next`=0 same edge onward.
